// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared stage-register definitions: default widths, ALUOp classes, control bundle.
// No logic; types and constants only.
// Imported by every pipeline-register file in the core.
package id_ex_pipe_reg_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;
  localparam int DEF_CNT_W  = 32;

  // ALU operation class produced by the ID-stage control unit
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_ANDI  = 2'b11
  } aluOp_e;

  // Control bits carried from ID to EX; zeroing the whole bundle makes a bubble
  typedef struct packed {
    logic   regDst;
    logic   jump;
    logic   beq;
    logic   bne;
    logic   memRead;
    logic   memReg;
    logic   memWrite;
    logic   ALUSrc;
    logic   regWrite;
    aluOp_e ALUOp;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX bundle: decoded ID inputs, registered EX outputs, hazard controls, counters.
// Latency is defined by the attached register; the bundle itself is wires.
// No handshake; the slave can only hold upstream through pcWrite/ifidWrite.
interface id_ex_pipe_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              flush;
  logic              id_regDst, id_jump, id_beq, id_bne, id_memRead;
  logic              id_memReg, id_memWrite, id_ALUSrc, id_regWrite;
  logic [1:0]        id_ALUOp;
  logic [DATA_W-1:0] id_pc4, id_rd1, id_rd2, id_imm;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;

  logic              ex_regDst, ex_jump, ex_beq, ex_bne, ex_memRead;
  logic              ex_memReg, ex_memWrite, ex_ALUSrc, ex_regWrite;
  logic [1:0]        ex_ALUOp;
  logic [DATA_W-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;

  logic              pcWrite, ifidWrite;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  modport master (
    output flush, id_regDst, id_jump, id_beq, id_bne, id_memRead, id_memReg,
           id_memWrite, id_ALUSrc, id_regWrite, id_ALUOp, id_pc4, id_rd1, id_rd2,
           id_imm, id_rs, id_rt, id_rd,
    input  ex_regDst, ex_jump, ex_beq, ex_bne, ex_memRead, ex_memReg, ex_memWrite,
           ex_ALUSrc, ex_regWrite, ex_ALUOp, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs,
           ex_rt, ex_rd, pcWrite, ifidWrite, stall_cnt, flush_cnt
  );

  modport slave (
    input  flush, id_regDst, id_jump, id_beq, id_bne, id_memRead, id_memReg,
           id_memWrite, id_ALUSrc, id_regWrite, id_ALUOp, id_pc4, id_rd1, id_rd2,
           id_imm, id_rs, id_rt, id_rd,
    output ex_regDst, ex_jump, ex_beq, ex_bne, ex_memRead, ex_memReg, ex_memWrite,
           ex_ALUSrc, ex_regWrite, ex_ALUOp, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs,
           ex_rt, ex_rd, pcWrite, ifidWrite, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// Load-use hazard detect: EX load whose destination is read by the ID instruction.
// Purely combinational, zero latency.
// No backpressure of its own; the caller turns hz into a stall.
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              exMemRead,
  input  logic [REG_AW-1:0] exRt,
  input  logic [REG_AW-1:0] idRs,
  input  logic [REG_AW-1:0] idRt,
  input  logic              idUsesRt,
  output logic              hz
);
  // rt of a load is its destination; $zero is never a real dependency
  assign hz = exMemRead && (exRt != '0) &&
              ((exRt == idRs) || ((exRt == idRt) && idUsesRt));
endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use stall, branch/jump flush and perf counters.
// Latency 1 cycle, registers load on every rising edge.
// Stall holds PC and IF/ID via pcWrite/ifidWrite and injects a bubble into EX.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           reset,
  id_ex_pipe_reg_if.slave bus
);
  logic              hz, stall, bubble, idUsesRt;
  ctrl_t             idCtrl, exCtrl;
  logic [DATA_W-1:0] exPc4, exRd1, exRd2, exImm;
  logic [REG_AW-1:0] exRs, exRt, exRd;
  logic [CNT_W-1:0]  stallCnt, flushCnt;

  // Instructions that read rt as a source: R-type, stores, branches
  assign idUsesRt = bus.id_regDst | bus.id_memWrite | bus.id_beq | bus.id_bne;

  load_use_detect #(.REG_AW(REG_AW)) u_loadUseDetect (
    .exMemRead (exCtrl.memRead),
    .exRt      (exRt),
    .idRs      (bus.id_rs),
    .idRt      (bus.id_rt),
    .idUsesRt  (idUsesRt),
    .hz        (hz)
  );

  // A flush already squashes the ID instruction, so it suppresses the stall
  assign stall         = hz & ~bus.flush & ~reset;
  assign bubble        = stall | bus.flush;
  assign bus.pcWrite   = ~stall;
  assign bus.ifidWrite = ~stall;

  assign idCtrl = '{
    regDst:   bus.id_regDst,
    jump:     bus.id_jump,
    beq:      bus.id_beq,
    bne:      bus.id_bne,
    memRead:  bus.id_memRead,
    memReg:   bus.id_memReg,
    memWrite: bus.id_memWrite,
    ALUSrc:   bus.id_ALUSrc,
    regWrite: bus.id_regWrite,
    ALUOp:    aluOp_e'(bus.id_ALUOp)
  };

  // Stage register plus saturating counters; data fields pass even in a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exCtrl   <= '0;
      exPc4    <= '0;
      exRd1    <= '0;
      exRd2    <= '0;
      exImm    <= '0;
      exRs     <= '0;
      exRt     <= '0;
      exRd     <= '0;
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      exCtrl <= bubble ? ctrl_t'('0) : idCtrl;
      exPc4  <= bus.id_pc4;
      exRd1  <= bus.id_rd1;
      exRd2  <= bus.id_rd2;
      exImm  <= bus.id_imm;
      exRs   <= bus.id_rs;
      exRt   <= bus.id_rt;
      exRd   <= bus.id_rd;
      if (stall && (stallCnt != '1)) stallCnt <= stallCnt + 1'b1;
      if (bus.flush && (flushCnt != '1)) flushCnt <= flushCnt + 1'b1;
    end
  end

  assign bus.ex_regDst   = exCtrl.regDst;
  assign bus.ex_jump     = exCtrl.jump;
  assign bus.ex_beq      = exCtrl.beq;
  assign bus.ex_bne      = exCtrl.bne;
  assign bus.ex_memRead  = exCtrl.memRead;
  assign bus.ex_memReg   = exCtrl.memReg;
  assign bus.ex_memWrite = exCtrl.memWrite;
  assign bus.ex_ALUSrc   = exCtrl.ALUSrc;
  assign bus.ex_regWrite = exCtrl.regWrite;
  assign bus.ex_ALUOp    = exCtrl.ALUOp;
  assign bus.ex_pc4      = exPc4;
  assign bus.ex_rd1      = exRd1;
  assign bus.ex_rd2      = exRd2;
  assign bus.ex_imm      = exImm;
  assign bus.ex_rs       = exRs;
  assign bus.ex_rt       = exRt;
  assign bus.ex_rd       = exRd;
  assign bus.stall_cnt   = stallCnt;
  assign bus.flush_cnt   = flushCnt;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed cases then randomized traffic vs a reference model.
// A 32-bit-counter and a 4-bit-counter instance see identical stimulus.
// The narrow instance exercises counter saturation.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        flush, regDst, jump, beq, bne, memRead, memReg, memWrite, ALUSrc, regWrite;
    logic [1:0]  ALUOp;
    logic [31:0] pc4, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
  } stim_t;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  stim_t cur = '0;
  stim_t exp = '0;
  longint unsigned expStall, expFlush;
  int unsigned     expStall4, expFlush4;
  int passCnt = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg_if #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) ifA ();
  id_ex_pipe_reg_if #(.DATA_W(32), .REG_AW(5), .CNT_W(4))  ifB ();

  assign ifA.flush = cur.flush;       assign ifB.flush = cur.flush;
  assign ifA.id_regDst = cur.regDst;  assign ifB.id_regDst = cur.regDst;
  assign ifA.id_jump = cur.jump;      assign ifB.id_jump = cur.jump;
  assign ifA.id_beq = cur.beq;        assign ifB.id_beq = cur.beq;
  assign ifA.id_bne = cur.bne;        assign ifB.id_bne = cur.bne;
  assign ifA.id_memRead = cur.memRead;   assign ifB.id_memRead = cur.memRead;
  assign ifA.id_memReg = cur.memReg;     assign ifB.id_memReg = cur.memReg;
  assign ifA.id_memWrite = cur.memWrite; assign ifB.id_memWrite = cur.memWrite;
  assign ifA.id_ALUSrc = cur.ALUSrc;     assign ifB.id_ALUSrc = cur.ALUSrc;
  assign ifA.id_regWrite = cur.regWrite; assign ifB.id_regWrite = cur.regWrite;
  assign ifA.id_ALUOp = cur.ALUOp;    assign ifB.id_ALUOp = cur.ALUOp;
  assign ifA.id_pc4 = cur.pc4;        assign ifB.id_pc4 = cur.pc4;
  assign ifA.id_rd1 = cur.rd1;        assign ifB.id_rd1 = cur.rd1;
  assign ifA.id_rd2 = cur.rd2;        assign ifB.id_rd2 = cur.rd2;
  assign ifA.id_imm = cur.imm;        assign ifB.id_imm = cur.imm;
  assign ifA.id_rs = cur.rs;          assign ifB.id_rs = cur.rs;
  assign ifA.id_rt = cur.rt;          assign ifB.id_rt = cur.rt;
  assign ifA.id_rd = cur.rd;          assign ifB.id_rd = cur.rd;

  id_ex_pipe_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) dutA (.clk(clk), .reset(reset), .bus(ifA));
  id_ex_pipe_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(4))  dutB (.clk(clk), .reset(reset), .bus(ifB));

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] want);
    totalCnt++;
    if (obs === want) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, want);
  endtask

  function automatic logic [10:0] ctrlOf(input stim_t x);
    return {x.regDst, x.jump, x.beq, x.bne, x.memRead, x.memReg, x.memWrite,
            x.ALUSrc, x.regWrite, x.ALUOp};
  endfunction

  function automatic logic [10:0] dutCtrl();
    return {ifA.ex_regDst, ifA.ex_jump, ifA.ex_beq, ifA.ex_bne, ifA.ex_memRead,
            ifA.ex_memReg, ifA.ex_memWrite, ifA.ex_ALUSrc, ifA.ex_regWrite, ifA.ex_ALUOp};
  endfunction

  task automatic modelReset();
    exp = '0;
    expStall = 0; expFlush = 0; expStall4 = 0; expFlush4 = 0;
  endtask

  task automatic checkAll(input string pfx);
    checkVal({pfx, "_ctrl"}, 64'(dutCtrl()), 64'(ctrlOf(exp)));
    checkVal({pfx, "_pc4"}, 64'(ifA.ex_pc4), 64'(exp.pc4));
    checkVal({pfx, "_rd1"}, 64'(ifA.ex_rd1), 64'(exp.rd1));
    checkVal({pfx, "_rd2"}, 64'(ifA.ex_rd2), 64'(exp.rd2));
    checkVal({pfx, "_imm"}, 64'(ifA.ex_imm), 64'(exp.imm));
    checkVal({pfx, "_regs"}, 64'({ifA.ex_rs, ifA.ex_rt, ifA.ex_rd}), 64'({exp.rs, exp.rt, exp.rd}));
    checkVal({pfx, "_stallCnt"}, 64'(ifA.stall_cnt), 64'(expStall));
    checkVal({pfx, "_flushCnt"}, 64'(ifA.flush_cnt), 64'(expFlush));
    checkVal({pfx, "_stallCnt4"}, 64'(ifB.stall_cnt), 64'(expStall4));
    checkVal({pfx, "_flushCnt4"}, 64'(ifB.flush_cnt), 64'(expFlush4));
  endtask

  // One cycle: apply inputs, check hold outputs, advance the model, check EX
  task automatic step(input string pfx, input stim_t st);
    logic usesRt, hzM, stallM;
    @(negedge clk);
    cur = st;
    #1;
    usesRt = st.regDst | st.memWrite | st.beq | st.bne;
    hzM    = exp.memRead && (exp.rt != 0) && ((exp.rt == st.rs) || ((exp.rt == st.rt) && usesRt));
    stallM = hzM && !st.flush;
    checkVal({pfx, "_pcWrite"}, 64'(ifA.pcWrite), 64'(!stallM));
    checkVal({pfx, "_ifidWrite"}, 64'(ifA.ifidWrite), 64'(!stallM));
    @(posedge clk);
    if (stallM) begin
      if (expStall < 64'hFFFF_FFFF) expStall++;
      if (expStall4 < 15) expStall4++;
    end
    if (st.flush) begin
      if (expFlush < 64'hFFFF_FFFF) expFlush++;
      if (expFlush4 < 15) expFlush4++;
    end
    exp = st;
    exp.flush = 1'b0;
    if (stallM || st.flush) begin
      {exp.regDst, exp.jump, exp.beq, exp.bne, exp.memRead, exp.memReg,
       exp.memWrite, exp.ALUSrc, exp.regWrite, exp.ALUOp} = '0;
    end
    #1;
    checkAll(pfx);
  endtask

  function automatic stim_t randStim();
    stim_t r;
    r = stim_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
    r.flush   = ($urandom_range(0, 7) == 0);
    r.memRead = $urandom_range(0, 1);
    r.rs      = 5'($urandom_range(0, 3));
    r.rt      = 5'($urandom_range(0, 3));
    return r;
  endfunction

  stim_t lw, add, s;

  initial begin
    modelReset();
    cur = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset asserted mid-cycle with every input high
    cur = '1;
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    modelReset();
    checkVal("rst_pcWrite", 64'(ifA.pcWrite), 64'd1);
    checkVal("rst_ifidWrite", 64'(ifA.ifidWrite), 64'd1);
    checkAll("rst");
    @(posedge clk);
    #1;
    checkAll("rstHeld");
    @(negedge clk);
    cur = '0;
    reset = 1'b0;

    // Plain pass-through
    s = '0;
    s.regWrite = 1'b1; s.ALUOp = 2'b10; s.rd1 = 32'h1234_5678; s.rd = 5'd8;
    step("pass", s);
    checkVal("pass_regWrite", 64'(ifA.ex_regWrite), 64'd1);
    checkVal("pass_ALUOp", 64'(ifA.ex_ALUOp), 64'd2);
    checkVal("pass_rd1", 64'(ifA.ex_rd1), 64'h1234_5678);
    checkVal("pass_rd", 64'(ifA.ex_rd), 64'd8);

    // Load-use: lw r9 then add using r9 as rs, held add then advances
    lw = '0;
    lw.memRead = 1'b1; lw.memReg = 1'b1; lw.ALUSrc = 1'b1; lw.regWrite = 1'b1; lw.rt = 5'd9;
    add = '0;
    add.regDst = 1'b1; add.regWrite = 1'b1; add.ALUOp = 2'b10; add.rs = 5'd9; add.rt = 5'd3; add.rd = 5'd4;
    step("lu_lw", lw);
    step("lu_add", add);
    checkVal("lu_bubble", 64'(dutCtrl()), 64'd0);
    checkVal("lu_stallCnt", 64'(ifA.stall_cnt), 64'd1);
    step("lu_addAgain", add);
    checkVal("lu_advance", 64'(ifA.ex_regDst & ifA.ex_regWrite), 64'd1);

    // No hazard: load into $zero, and addi whose rt is only a destination
    s = lw; s.rt = 5'd0;
    step("nz_lw0", s);
    s = add; s.rs = 5'd0;
    step("nz_add0", s);
    step("nz_lw9", lw);
    s = '0; s.ALUSrc = 1'b1; s.regWrite = 1'b1; s.rs = 5'd1; s.rt = 5'd9;
    step("nz_addi", s);
    checkVal("nz_stallCnt", 64'(ifA.stall_cnt), 64'd1);

    // Flush and hazard together: flush wins
    step("fh_lw", lw);
    s = add; s.flush = 1'b1;
    step("fh_add", s);
    checkVal("fh_flushCnt", 64'(ifA.flush_cnt), 64'd1);
    checkVal("fh_stallCnt", 64'(ifA.stall_cnt), 64'd1);

    // Randomized traffic; the narrow counters saturate along the way
    for (int i = 0; i < 2000; i++) step("rnd", randStim());
    checkVal("sat_stall4", 64'(ifB.stall_cnt), 64'hF);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
